// File: rtl/imem_loader_encoder_if.sv
// Handshake and memory-write bundle between an instruction source and the loader/encoder.
// The master drives the symbolic instruction stream; the slave (the loader) drives the memory-side outputs.
interface imem_loader_encoder_if #(
    parameter int ADDR_W = 6
);
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        mnem;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [15:0]       imm;
    logic [25:0]       target;
    logic              last;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic [ADDR_W:0]   count;
    logic              cpu_run;
    logic [1:0]        err;

    modport master (
        output start, in_valid, mnem, rs, rt, rd, imm, target, last,
        input  in_ready, imem_we, imem_addr, imem_wdata, count, cpu_run, err
    );

    modport slave (
        input  start, in_valid, mnem, rs, rt, rd, imm, target, last,
        output in_ready, imem_we, imem_addr, imem_wdata, count, cpu_run, err
    );
endinterface

// File: rtl/imem_loader_encoder.sv
// Encodes symbolic MIPS instructions and writes them sequentially into instruction memory,
// holding the CPU idle until the whole program has been loaded.
module imem_loader_encoder #(
    parameter int ADDR_W = 6
) (
    input logic                   clk,
    input logic                   clrn,
    imem_loader_encoder_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, LOAD, DONE, ERROR} state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] ptr_reg, ptr_next;
    logic [ADDR_W:0]   count_reg, count_next;
    logic [1:0]        err_reg, err_next;
    logic              we_reg, we_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [31:0]       wdata_reg, wdata_next;

    logic [31:0]       enc_word;
    logic              enc_legal;

    always_comb begin
        enc_word  = 32'h0;
        enc_legal = 1'b1;
        case (bus.mnem)
            4'd0:    enc_word = {6'b000000, bus.rs, bus.rt, bus.rd, 5'b0, 6'b100000};
            4'd1:    enc_word = {6'b000000, bus.rs, bus.rt, bus.rd, 5'b0, 6'b100010};
            4'd2:    enc_word = {6'b000000, bus.rs, bus.rt, bus.rd, 5'b0, 6'b100100};
            4'd3:    enc_word = {6'b000000, bus.rs, bus.rt, bus.rd, 5'b0, 6'b100101};
            4'd4:    enc_word = {6'b001000, bus.rs, bus.rt, bus.imm};
            4'd5:    enc_word = {6'b001100, bus.rs, bus.rt, bus.imm};
            4'd6:    enc_word = {6'b001101, bus.rs, bus.rt, bus.imm};
            4'd7:    enc_word = {6'b100011, bus.rs, bus.rt, bus.imm};
            4'd8:    enc_word = {6'b101011, bus.rs, bus.rt, bus.imm};
            4'd9:    enc_word = {6'b000100, bus.rs, bus.rt, bus.imm};
            4'd10:   enc_word = {6'b000101, bus.rs, bus.rt, bus.imm};
            4'd11:   enc_word = {6'b000010, bus.target};
            default: enc_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        count_next = count_reg;
        err_next   = err_reg;
        we_next    = 1'b0;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        // Start wins over any transfer offered in the same cycle, from every state.
        if (bus.start) begin
            state_next = LOAD;
            ptr_next   = '0;
            count_next = '0;
            err_next   = 2'b00;
        end else if (state_reg == LOAD && bus.in_valid) begin
            if (!enc_legal) begin
                err_next   = 2'b01;
                state_next = ERROR;
            end else begin
                we_next    = 1'b1;
                addr_next  = ptr_reg;
                wdata_next = enc_word;
                ptr_next   = ptr_reg + ADDR_W'(1);
                count_next = count_reg + (ADDR_W+1)'(1);
                if (bus.last) begin
                    state_next = DONE;
                end else if (&ptr_reg) begin
                    // Memory full with more program to come: keep the word, refuse to wrap.
                    err_next   = 2'b10;
                    state_next = ERROR;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_reg <= IDLE;
            ptr_reg   <= '0;
            count_reg <= '0;
            err_reg   <= 2'b00;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= 32'h0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            count_reg <= count_next;
            err_reg   <= err_next;
            we_reg    <= we_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
        end
    end

    assign bus.in_ready   = (state_reg == LOAD);
    assign bus.cpu_run    = (state_reg == DONE);
    assign bus.err        = err_reg;
    assign bus.count      = count_reg;
    assign bus.imem_we    = we_reg;
    assign bus.imem_addr  = addr_reg;
    assign bus.imem_wdata = wdata_reg;
endmodule
